// File: rtl/sad_min_search.sv
`default_nettype none
// ============================================================================
// Module   : sad_min_search
// Purpose  : Reduces rows of PE-array absolute differences into candidate
//            SADs and keeps the minimum SAD and its motion vector over a
//            full raster-ordered search window.
// Ports    : clk, rst (async, active-high)
//            start        - one-cycle pulse, begins (or restarts) a search
//            diff_valid   - abs_diff_row carries one valid row
//            abs_diff_row - NUM_PE packed unsigned lanes, lane 0 in LSBs
//            busy         - search in progress (RUN or DRAIN)
//            done         - one-cycle pulse, best_* final
//            best_sad     - minimum candidate SAD
//            best_mv_x/y  - signed motion vector of the best candidate
// Revision : 1.0 - initial release
// ============================================================================
module sad_min_search #(
  parameter int PIX_WIDTH = 8,
  parameter int NUM_PE    = 16,
  parameter int BLK_ROWS  = 16,
  parameter int SEARCH_W  = 16,
  parameter int SEARCH_H  = 16,
  parameter int SAD_WIDTH = 16,
  parameter int MV_WIDTH  = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        diff_valid,
  input  logic [NUM_PE*PIX_WIDTH-1:0] abs_diff_row,
  output logic                        busy,
  output logic                        done,
  output logic [SAD_WIDTH-1:0]        best_sad,
  output logic signed [MV_WIDTH-1:0]  best_mv_x,
  output logic signed [MV_WIDTH-1:0]  best_mv_y
);

  localparam int c_BR_W  = (BLK_ROWS > 1) ? $clog2(BLK_ROWS) : 1;
  localparam int c_COL_W = (SEARCH_W > 1) ? $clog2(SEARCH_W) : 1;
  localparam int c_ROW_W = (SEARCH_H > 1) ? $clog2(SEARCH_H) : 1;

  localparam logic [c_BR_W-1:0]   c_BR_LAST  = c_BR_W'(BLK_ROWS - 1);
  localparam logic [c_COL_W-1:0]  c_COL_LAST = c_COL_W'(SEARCH_W - 1);
  localparam logic [c_ROW_W-1:0]  c_ROW_LAST = c_ROW_W'(SEARCH_H - 1);
  localparam logic [MV_WIDTH-1:0] c_X_OFF    = MV_WIDTH'(SEARCH_W / 2);
  localparam logic [MV_WIDTH-1:0] c_Y_OFF    = MV_WIDTH'(SEARCH_H / 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t               r_state;

  // Position of the next row to be sampled
  logic [c_BR_W-1:0]    r_brow;
  logic [c_COL_W-1:0]   r_col;
  logic [c_ROW_W-1:0]   r_crow;

  // Stage 1: registered row sum plus the row's bookkeeping
  logic                 r_vld_q;
  logic [SAD_WIDTH-1:0] r_row_sum_q;
  logic                 r_first_q;
  logic                 r_last_q;
  logic                 r_first_cand_q;
  logic [c_COL_W-1:0]   r_col_q;
  logic [c_ROW_W-1:0]   r_crow_q;

  // Stage 2: candidate accumulator
  logic [SAD_WIDTH-1:0] r_acc;

  logic [SAD_WIDTH-1:0] w_row_sum;
  logic [SAD_WIDTH-1:0] w_acc_next;
  logic                 w_take;
  logic                 w_row_last;
  logic                 w_col_last;
  logic                 w_crow_last;
  logic                 w_final_row;
  logic                 w_better;

  always_comb begin
    w_row_sum = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      w_row_sum = w_row_sum + SAD_WIDTH'(abs_diff_row[i*PIX_WIDTH +: PIX_WIDTH]);
    end
  end

  // A row is only consumed in RUN; a row arriving with start is dropped so
  // the new search counts from the following cycle.
  assign w_take      = (r_state == S_RUN) && diff_valid && !start;
  assign w_row_last  = (r_brow == c_BR_LAST);
  assign w_col_last  = (r_col  == c_COL_LAST);
  assign w_crow_last = (r_crow == c_ROW_LAST);
  assign w_final_row = w_take && w_row_last && w_col_last && w_crow_last;

  assign w_acc_next  = (r_first_q ? '0 : r_acc) + r_row_sum_q;
  // First candidate loads unconditionally; strict less-than keeps the
  // earlier raster candidate on ties.
  assign w_better    = r_first_cand_q || (w_acc_next < best_sad);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_brow         <= '0;
      r_col          <= '0;
      r_crow         <= '0;
      r_vld_q        <= 1'b0;
      r_row_sum_q    <= '0;
      r_first_q      <= 1'b0;
      r_last_q       <= 1'b0;
      r_first_cand_q <= 1'b0;
      r_col_q        <= '0;
      r_crow_q       <= '0;
      r_acc          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      best_sad       <= '0;
      best_mv_x      <= '0;
      best_mv_y      <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        // Abort anything in flight; best_* survive until the new first compare
        r_state <= S_RUN;
        busy    <= 1'b1;
        r_brow  <= '0;
        r_col   <= '0;
        r_crow  <= '0;
        r_vld_q <= 1'b0;
        r_acc   <= '0;
      end else begin
        r_vld_q <= w_take;
        if (w_take) begin
          r_row_sum_q    <= w_row_sum;
          r_first_q      <= (r_brow == '0);
          r_last_q       <= w_row_last;
          r_first_cand_q <= (r_col == '0) && (r_crow == '0);
          r_col_q        <= r_col;
          r_crow_q       <= r_crow;
          if (w_row_last) begin
            r_brow <= '0;
            if (w_col_last) begin
              r_col  <= '0;
              r_crow <= w_crow_last ? '0 : r_crow + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end else begin
            r_brow <= r_brow + 1'b1;
          end
        end

        if (r_vld_q) begin
          r_acc <= w_acc_next;
          if (r_last_q && w_better) begin
            best_sad  <= w_acc_next;
            best_mv_x <= MV_WIDTH'(r_col_q) - c_X_OFF;
            best_mv_y <= MV_WIDTH'(r_crow_q) - c_Y_OFF;
          end
        end

        case (r_state)
          S_IDLE: begin
            r_state <= S_IDLE;
          end
          S_RUN: begin
            if (w_final_row) begin
              r_state <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            // The final candidate compares on this edge
            if (r_vld_q) begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sad_min_search.sv
`default_nettype none
// ============================================================================
// Module   : tb_sad_min_search
// Purpose  : Self-checking bench for sad_min_search. One instance at default
//            parameters, one at a small window (4x2 candidates, 2 rows,
//            4 lanes). A reference model sums each candidate's lanes and
//            picks the raster-first minimum.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sad_min_search;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Default-parameter instance
  logic                a_start, a_vld;
  logic [127:0]        a_row;
  logic                a_busy, a_done;
  logic [15:0]         a_sad;
  logic signed [4:0]   a_x, a_y;

  // Small-window instance
  logic                b_start, b_vld;
  logic [31:0]         b_row;
  logic                b_busy, b_done;
  logic [15:0]         b_sad;
  logic signed [4:0]   b_x, b_y;

  sad_min_search u_dut_a (
    .clk          (clk),
    .rst          (rst),
    .start        (a_start),
    .diff_valid   (a_vld),
    .abs_diff_row (a_row),
    .busy         (a_busy),
    .done         (a_done),
    .best_sad     (a_sad),
    .best_mv_x    (a_x),
    .best_mv_y    (a_y)
  );

  sad_min_search #(
    .PIX_WIDTH (8),
    .NUM_PE    (4),
    .BLK_ROWS  (2),
    .SEARCH_W  (4),
    .SEARCH_H  (2),
    .SAD_WIDTH (16),
    .MV_WIDTH  (5)
  ) u_dut_b (
    .clk          (clk),
    .rst          (rst),
    .start        (b_start),
    .diff_valid   (b_vld),
    .abs_diff_row (b_row),
    .busy         (b_busy),
    .done         (b_done),
    .best_sad     (b_sad),
    .best_mv_x    (b_x),
    .best_mv_y    (b_y)
  );

  int checks = 0;
  int errors = 0;
  int dca    = 0;
  int dcb    = 0;

  always @(negedge clk) begin
    if (a_done === 1'b1) dca++;
    if (b_done === 1'b1) dcb++;
  end

  // Selects which instance the generic tasks drive and observe
  logic              dsel;
  logic              m_done, m_busy;
  logic [15:0]       m_sad;
  logic [4:0]        m_x, m_y;
  assign m_done = dsel ? b_done : a_done;
  assign m_busy = dsel ? b_busy : a_busy;
  assign m_sad  = dsel ? b_sad  : a_sad;
  assign m_x    = dsel ? b_x    : a_x;
  assign m_y    = dsel ? b_y    : a_y;

  function automatic logic [127:0] rnd_row();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Lane value for candidate c under a stimulus pattern
  function automatic int lane_val(input int pat, input int c, input int sw);
    case (pat)
      1:       return 255;
      2:       return (c == 15 * sw) ? 0 : int'($urandom_range(1, 255));
      3:       return (c == 7) ? 1 : 10;
      4:       return 5;
      5:       return int'($urandom_range(0, 3));
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic set_in(input logic st, input logic v, input logic [127:0] row);
    if (dsel) begin
      b_start = st; b_vld = v; b_row = row[31:0];
    end else begin
      a_start = st; a_vld = v; a_row = row;
    end
  endtask

  task automatic cyc(input logic st, input logic v, input logic [127:0] row);
    set_in(st, v, row);
    @(posedge clk);
    #1;
  endtask

  // Issues start, streams a complete search with random stalls, then checks
  // done timing and the result against the model.
  task automatic run_search(input int pat, input int duty, input logic st_vld,
                            input string name);
    int npe, blk, sw, sh, bi, v, ex, ey, dc0;
    int csad[256];
    logic [127:0] row;
    npe = dsel ? 4 : 16;
    blk = dsel ? 2 : 16;
    sw  = dsel ? 4 : 16;
    sh  = dsel ? 2 : 16;
    dc0 = dsel ? dcb : dca;
    cyc(1'b1, st_vld, rnd_row());
    for (int c = 0; c < sw * sh; c++) begin
      csad[c] = 0;
      for (int r = 0; r < blk; r++) begin
        row = '0;
        for (int l = 0; l < npe; l++) begin
          v = lane_val(pat, c, sw);
          row[l*8 +: 8] = 8'(v);
          csad[c] += v;
        end
        while (int'($urandom_range(0, 99)) < duty) cyc(1'b0, 1'b0, rnd_row());
        cyc(1'b0, 1'b1, row);
        if (c == 0 && r == 0) begin
          checks++;
          if (m_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy_run: got %0b want 1", name, m_busy);
          end
        end
      end
    end
    set_in(1'b0, 1'b0, '0);
    bi = 0;
    for (int c = 1; c < sw * sh; c++) if (csad[c] < csad[bi]) bi = c;
    ex = (bi % sw) - sw / 2;
    ey = (bi / sw) - sh / 2;

    @(negedge clk);
    checks++;
    if (m_done !== 1'b0 || m_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_drain: got done=%0b busy=%0b want done=0 busy=1", name, m_done, m_busy);
    end
    @(negedge clk);
    checks++;
    if (m_done !== 1'b1 || m_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: got done=%0b busy=%0b want done=1 busy=0", name, m_done, m_busy);
    end
    checks++;
    if (m_sad !== 16'(csad[bi])) begin
      errors++;
      $display("FAIL %s_sad: got %0d want %0d", name, m_sad, csad[bi]);
    end
    checks++;
    if (m_x !== 5'(ex) || m_y !== 5'(ey)) begin
      errors++;
      $display("FAIL %s_mv: got (%0d,%0d) want (%0d,%0d)", name,
               $signed(m_x), $signed(m_y), ex, ey);
    end
    @(negedge clk);
    checks++;
    if (m_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_pulse: got %0b want 0", name, m_done);
    end
    checks++;
    if ((dsel ? dcb : dca) - dc0 != 1) begin
      errors++;
      $display("FAIL %s_done_count: got %0d want 1", name, (dsel ? dcb : dca) - dc0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dsel = 1'b1; set_in(1'b0, 1'b0, '0);
    dsel = 1'b0; set_in(1'b0, 1'b0, '0);
    #12;
    checks++;
    if (a_busy !== 1'b0 || a_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_a_ctrl: got busy=%0b done=%0b want 0 0", a_busy, a_done);
    end
    checks++;
    if (a_sad !== 16'd0 || a_x !== 5'd0 || a_y !== 5'd0) begin
      errors++;
      $display("FAIL reset_a_best: got sad=%0d x=%0d y=%0d want 0", a_sad, a_x, a_y);
    end
    checks++;
    if (b_busy !== 1'b0 || b_done !== 1'b0 || b_sad !== 16'd0) begin
      errors++;
      $display("FAIL reset_b: got busy=%0b done=%0b sad=%0d want 0", b_busy, b_done, b_sad);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    dsel = 1'b0;
    cyc(1'b1, 1'b0, '0);
    for (int i = 0; i < 50; i++) cyc(1'b0, 1'b1, rnd_row() | {16{8'h01}});
    set_in(1'b0, 1'b0, '0);
    checks++;
    if (a_sad === 16'd0 || a_busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: got sad=%0d busy=%0b want sad>0 busy=1", a_sad, a_busy);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (a_busy !== 1'b0 || a_done !== 1'b0 || a_sad !== 16'd0 ||
        a_x !== 5'd0 || a_y !== 5'd0) begin
      errors++;
      $display("FAIL midrst_async: got busy=%0b done=%0b sad=%0d x=%0d y=%0d want all 0",
               a_busy, a_done, a_sad, a_x, a_y);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_search(0, 30, 1'b0, "post_reset");
  endtask

  task automatic test_small_patterns();
    dsel = 1'b1;
    run_search(3, 0, 1'b0, "single_min");
    run_search(4, 30, 1'b0, "tie");
    run_search(5, 40, 1'b0, "small_rand_ties");
    run_search(0, 20, 1'b0, "small_rand");
  endtask

  task automatic test_stall();
    dsel = 1'b0;
    run_search(1, 50, 1'b0, "stall");
  endtask

  task automatic test_restart();
    int dc0;
    dsel = 1'b0;
    dc0 = dca;
    cyc(1'b1, 1'b0, '0);
    for (int i = 0; i < 37; i++) cyc(1'b0, 1'b1, rnd_row() | {16{8'h01}});
    checks++;
    if (a_busy !== 1'b1 || dca != dc0) begin
      errors++;
      $display("FAIL restart_pre: got busy=%0b dones=%0d want busy=1 dones=0", a_busy, dca - dc0);
    end
    run_search(2, 20, 1'b1, "restart");
    checks++;
    if (dca - dc0 != 1) begin
      errors++;
      $display("FAIL restart_total_done: got %0d want 1", dca - dc0);
    end
  endtask

  task automatic test_ignored();
    int dc0;
    dsel = 1'b0;
    dc0 = dca;
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, rnd_row());
    checks++;
    if (a_busy !== 1'b0 || dca != dc0) begin
      errors++;
      $display("FAIL idle_a: got busy=%0b dones=%0d want 0 0", a_busy, dca - dc0);
    end
    run_search(0, 0, 1'b1, "ignored_a");
    dsel = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, rnd_row());
    checks++;
    if (b_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_b: got busy=%0b want 0", b_busy);
    end
    run_search(5, 10, 1'b1, "ignored_b");
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_small_patterns();
    test_stall();
    test_restart();
    test_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/sad_min_search.md
Name: sad_min_search

Overview:
- Downstream consumer of the motion-estimation PE array.
- Each valid cycle it takes one row of NUM_PE absolute differences from the PE array, sums the row through a registered adder stage, and accumulates BLK_ROWS rows into one candidate SAD.
- It compares each candidate SAD against the running minimum and, after the full search window, reports the best SAD and its motion vector to the mode-decision / MV-prediction stage.

Parameters:
- PIX_WIDTH, 8, width of each abs_diff lane
- NUM_PE, 16, abs_diff lanes per row (PE array columns)
- BLK_ROWS, 16, rows per candidate block
- SEARCH_W, 16, candidate columns; mv_x = col - SEARCH_W/2
- SEARCH_H, 16, candidate rows; mv_y = row - SEARCH_H/2
- SAD_WIDTH, 16, accumulator/best_sad width; must be at least PIX_WIDTH+clog2(NUM_PE*BLK_ROWS)
- MV_WIDTH, 5, signed MV component width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse that begins a new macroblock search
- diff_valid  in  1  abs_diff_row holds one valid row
- abs_diff_row  in  NUM_PE*PIX_WIDTH  packed unsigned lanes; lane 0 = bits [PIX_WIDTH-1:0]
- busy  out  1  search in progress
- done  out  1  one-cycle pulse; best_* outputs final
- best_sad  out  SAD_WIDTH  minimum candidate SAD
- best_mv_x  out  MV_WIDTH  signed x of best candidate
- best_mv_y  out  MV_WIDTH  signed y of best candidate

Behaviour:
- Reset (async): busy=0, done=0, best_sad=0, best_mv_x=0, best_mv_y=0. All counters, the accumulator, the pipeline valid bit and the FSM clear. FSM goes to IDLE.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start.
  - RUN -> DRAIN when the row of the last candidate (last row of the last candidate) is sampled.
  - DRAIN -> IDLE after the final compare edge, with done=1 for one cycle.
- busy=1 in RUN and DRAIN.
- Candidate order is raster: column index increments fastest, then row index. Total SEARCH_W*SEARCH_H candidates. Each candidate consumes exactly BLK_ROWS valid rows.
- Stage 1 (registered adder):
  - At the edge sampling diff_valid=1 in RUN: row_sum_q <= zero-extended sum of all NUM_PE lanes; vld_q <= 1.
  - A row-last flag and the candidate col/row indices are registered alongside.
- Stage 2 (accumulate/compare):
  - At the edge where vld_q=1: acc <= (first row of candidate ? 0 : acc) + row_sum_q.
  - If the row is the candidate's last row, form cand_sad = that same value. Update best_sad/best_mv_x/best_mv_y if this is the first candidate of the search or cand_sad < best_sad.
- Ties keep the earlier candidate (strict less-than), so raster order wins.
- Latency: the last row sampled at edge E gives the best_* update at edge E+1. For the final candidate, done=1 in the cycle following E+1 and best_* are final in that same cycle.
- diff_valid=0 in RUN is a stall: counters, acc and best hold. The pipeline still drains vld_q. There is no limit on gaps.
- diff_valid is ignored in IDLE and DRAIN.
- best_* hold their final values after done until the next search's first candidate compare.
- start while busy: abort and restart. Counters, acc and vld_q clear; the state stays or becomes RUN; no done is issued for the aborted search; best_* keep their old values until the new first compare.
- start with diff_valid in the same cycle: that row is ignored; rows count from the next cycle.
- Arithmetic is unsigned with no saturation. The width rule on SAD_WIDTH guarantees no overflow; the maximum at defaults is 255*256=65280.
- MV arithmetic is two's complement. At defaults mv_x, mv_y span -8..+7.

Test Plan:
- Reset mid-search: assert rst asynchronously between clock edges during RUN -> all outputs 0 immediately, busy=0; a subsequent start runs a clean search.
- Single-minimum search (SEARCH_W=4, SEARCH_H=2, BLK_ROWS=2, NUM_PE=4): all lanes 10 except the candidate at col 3 row 1, whose lanes are 1 -> done once, best_sad=8, best_mv_x=+1, best_mv_y=0, busy falls with done.
- Tie and first-candidate load (same small params): all lanes 5 for every candidate -> best_sad=40, best_mv_x=-2, best_mv_y=-1 (first raster candidate retained).
- Stall and latency (defaults): all lanes 255 with a random diff_valid duty of about 50% -> best_sad=65280, best_mv=(-8,-8); done exactly 2 cycles after the edge sampling the final row.
- Restart: issue start mid-search after 37 rows, then a full search with the minimum at candidate (col 0, row 15) holding all lanes 0 -> a single done, best_sad=0, best_mv_x=-8, best_mv_y=+7.
- Ignored inputs: diff_valid=1 pulses in IDLE and in the start cycle -> no counter advance; the following search result is identical to a clean run.
